// File: rtl/multi_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_controller
// Brief    : Multi-cycle MIPS-subset control FSM with bus-timeout trap and
//            retired-instruction counter.
// Revision : 1.0
// ============================================================================
module multi_cycle_controller #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        ALUIMM,
    output logic [2:0]  aluop,
    output logic        imm_zext,
    output logic        memread,
    output logic        memwrite,
    output logic        irwrite,
    output logic        pcwrite,
    output logic        regwrite,
    output logic        regdst,
    output logic        memtoreg,
    output logic [1:0]  pcsrc,
    output logic [2:0]  state,
    output logic [1:0]  trap_cause,
    output logic [15:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [3:0] c_CLS_ILL  = 4'd0;
    localparam logic [3:0] c_CLS_R    = 4'd1;
    localparam logic [3:0] c_CLS_ADDI = 4'd2;
    localparam logic [3:0] c_CLS_ANDI = 4'd3;
    localparam logic [3:0] c_CLS_ORI  = 4'd4;
    localparam logic [3:0] c_CLS_LW   = 4'd5;
    localparam logic [3:0] c_CLS_SW   = 4'd6;
    localparam logic [3:0] c_CLS_BEQ  = 4'd7;
    localparam logic [3:0] c_CLS_J    = 4'd8;

    localparam logic [1:0] c_TRAP_ILL = 2'd1;
    localparam logic [1:0] c_TRAP_TMO = 2'd2;
    localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT - 1);

    function automatic logic [3:0] f_class(input logic [5:0] op, input logic [5:0] fn);
        logic [3:0] cls;
        cls = c_CLS_ILL;
        case (op)
            6'h00: begin
                case (fn)
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: cls = c_CLS_R;
                    default:                           cls = c_CLS_ILL;
                endcase
            end
            6'h08:   cls = c_CLS_ADDI;
            6'h0C:   cls = c_CLS_ANDI;
            6'h0D:   cls = c_CLS_ORI;
            6'h23:   cls = c_CLS_LW;
            6'h2B:   cls = c_CLS_SW;
            6'h04:   cls = c_CLS_BEQ;
            6'h02:   cls = c_CLS_J;
            default: cls = c_CLS_ILL;
        endcase
        return cls;
    endfunction

    function automatic logic [2:0] f_rop(input logic [5:0] fn);
        logic [2:0] op;
        case (fn)
            6'h22:   op = 3'd1;
            6'h24:   op = 3'd2;
            6'h25:   op = 3'd3;
            6'h2A:   op = 3'd4;
            default: op = 3'd0;
        endcase
        return op;
    endfunction

    state_t      r_state;
    logic        r_run;
    logic [5:0]  r_op;
    logic [5:0]  r_funct;
    logic [7:0]  r_wait;
    logic [1:0]  r_cause;
    logic [15:0] r_instret;

    state_t      w_next;
    logic [1:0]  w_next_cause;
    logic        w_retire;
    logic        w_wait_hit;
    logic [3:0]  w_dec_cls;
    logic [3:0]  w_cls;
    logic        w_ex_aluimm;
    logic [2:0]  w_ex_aluop;
    logic        w_ex_zext;
    logic        w_unused_instr;

    assign w_unused_instr = ^instr[25:6];
    assign w_dec_cls      = f_class(instr[31:26], instr[5:0]);
    assign w_cls          = f_class(r_op, r_funct);
    assign w_wait_hit     = (r_wait == c_WAIT_LAST);

    always_comb begin
        w_next       = r_state;
        w_next_cause = r_cause;
        w_retire     = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (mem_ready) begin
                    w_next = S_DECODE;
                end else if (w_wait_hit) begin
                    w_next       = S_TRAP;
                    w_next_cause = c_TRAP_TMO;
                end
            end
            S_DECODE: begin
                if (w_dec_cls == c_CLS_ILL) begin
                    w_next       = S_TRAP;
                    w_next_cause = c_TRAP_ILL;
                end else if (w_dec_cls == c_CLS_J) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                case (w_cls)
                    c_CLS_R, c_CLS_ADDI, c_CLS_ANDI, c_CLS_ORI: w_next = S_WB;
                    c_CLS_LW, c_CLS_SW:                         w_next = S_MEM;
                    c_CLS_BEQ: begin
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end
                    default: begin
                        w_next       = S_TRAP;
                        w_next_cause = c_TRAP_ILL;
                    end
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (w_cls == c_CLS_SW) begin
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_wait_hit) begin
                    w_next       = S_TRAP;
                    w_next_cause = c_TRAP_TMO;
                end
            end
            S_WB: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_TRAP: w_next = S_TRAP;
            default: begin
                w_next       = S_TRAP;
                w_next_cause = c_TRAP_ILL;
            end
        endcase
    end

    // r_run holds the block idle until the first clock edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_run     <= 1'b0;
            r_op      <= 6'd0;
            r_funct   <= 6'd0;
            r_wait    <= 8'd0;
            r_cause   <= 2'd0;
            r_instret <= 16'd0;
        end else if (!r_run) begin
            r_run <= 1'b1;
        end else begin
            r_state <= w_next;
            r_cause <= w_next_cause;
            if (r_state == S_DECODE) begin
                r_op    <= instr[31:26];
                r_funct <= instr[5:0];
            end
            if ((w_next == r_state) && ((r_state == S_FETCH) || (r_state == S_MEM))) begin
                r_wait <= r_wait + 8'd1;
            end else begin
                r_wait <= 8'd0;
            end
            if (w_retire) begin
                r_instret <= r_instret + 16'd1;
            end
        end
    end

    always_comb begin
        w_ex_aluimm = 1'b0;
        w_ex_aluop  = 3'd0;
        w_ex_zext   = 1'b0;
        case (w_cls)
            c_CLS_R:    w_ex_aluop = f_rop(r_funct);
            c_CLS_ADDI: w_ex_aluimm = 1'b1;
            c_CLS_ANDI: begin
                w_ex_aluimm = 1'b1;
                w_ex_aluop  = 3'd2;
                w_ex_zext   = 1'b1;
            end
            c_CLS_ORI: begin
                w_ex_aluimm = 1'b1;
                w_ex_aluop  = 3'd3;
                w_ex_zext   = 1'b1;
            end
            c_CLS_LW, c_CLS_SW: w_ex_aluimm = 1'b1;
            c_CLS_BEQ:          w_ex_aluop  = 3'd1;
            default:            w_ex_aluimm = 1'b0;
        endcase
    end

    always_comb begin
        ALUIMM   = 1'b0;
        aluop    = 3'd0;
        imm_zext = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        pcwrite  = 1'b0;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        pcsrc    = 2'd0;
        if (r_run) begin
            case (r_state)
                S_FETCH: begin
                    memread = 1'b1;
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                end
                S_DECODE: begin
                    if (w_dec_cls == c_CLS_J) begin
                        pcwrite = 1'b1;
                        pcsrc   = 2'd2;
                    end
                end
                S_EXEC: begin
                    ALUIMM   = w_ex_aluimm;
                    aluop    = w_ex_aluop;
                    imm_zext = w_ex_zext;
                    if (w_cls == c_CLS_BEQ) begin
                        pcsrc   = 2'd1;
                        pcwrite = zero;
                    end
                end
                S_MEM: begin
                    ALUIMM   = w_ex_aluimm;
                    aluop    = w_ex_aluop;
                    imm_zext = w_ex_zext;
                    memread  = (w_cls == c_CLS_LW);
                    memwrite = (w_cls == c_CLS_SW);
                end
                S_WB: begin
                    ALUIMM   = w_ex_aluimm;
                    aluop    = w_ex_aluop;
                    imm_zext = w_ex_zext;
                    regwrite = 1'b1;
                    regdst   = (w_cls == c_CLS_R);
                    memtoreg = (w_cls == c_CLS_LW);
                end
                default: ALUIMM = 1'b0;
            endcase
        end
    end

    assign state      = r_state;
    assign trap_cause = (r_state == S_TRAP) ? r_cause : 2'd0;
    assign instret    = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_cycle_controller
// Brief    : Directed and randomized self-checking bench for the controller.
// Revision : 1.0
// ============================================================================
module tb_multi_cycle_controller;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        zero;
    logic        a_mr, b_mr;

    logic        a_aluimm, a_zext, a_mrd, a_mwr, a_irw, a_pcw, a_rw, a_rd, a_m2r;
    logic [2:0]  a_aluop, a_state;
    logic [1:0]  a_pcsrc, a_tc;
    logic [15:0] a_instret;
    logic        b_aluimm, b_zext, b_mrd, b_mwr, b_irw, b_pcw, b_rw, b_rd, b_m2r;
    logic [2:0]  b_aluop, b_state;
    logic [1:0]  b_pcsrc, b_tc;
    logic [15:0] b_instret;
    logic [18:0] a_obs, b_obs;

    int errors = 0;
    int checks = 0;
    int m_ret  = 0;

    logic [18:0] q_exp[$];
    bit          q_mr[$];
    logic [31:0] q_ins[$];
    bit          q_z[$];
    logic [5:0]  ops[9]    = '{6'h00, 6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h02};
    logic [5:0]  functs[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    assign a_obs = {a_aluimm, a_aluop, a_zext, a_mrd, a_mwr, a_irw, a_pcw, a_rw, a_rd, a_m2r, a_pcsrc, a_state, a_tc};
    assign b_obs = {b_aluimm, b_aluop, b_zext, b_mrd, b_mwr, b_irw, b_pcw, b_rw, b_rd, b_m2r, b_pcsrc, b_state, b_tc};

    multi_cycle_controller #(.TIMEOUT(15)) dut_a (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(a_mr),
        .ALUIMM(a_aluimm), .aluop(a_aluop), .imm_zext(a_zext), .memread(a_mrd),
        .memwrite(a_mwr), .irwrite(a_irw), .pcwrite(a_pcw), .regwrite(a_rw),
        .regdst(a_rd), .memtoreg(a_m2r), .pcsrc(a_pcsrc), .state(a_state),
        .trap_cause(a_tc), .instret(a_instret)
    );

    multi_cycle_controller #(.TIMEOUT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(b_mr),
        .ALUIMM(b_aluimm), .aluop(b_aluop), .imm_zext(b_zext), .memread(b_mrd),
        .memwrite(b_mwr), .irwrite(b_irw), .pcwrite(b_pcw), .regwrite(b_rw),
        .regdst(b_rd), .memtoreg(b_m2r), .pcsrc(b_pcsrc), .state(b_state),
        .trap_cause(b_tc), .instret(b_instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs the expected outputs in the same bit order as a_obs/b_obs
    function automatic logic [18:0] pk(input bit ai, input logic [2:0] op, input bit zx,
                                       input bit mrd, mwr, irw, pcw, rw, rd, m2r,
                                       input logic [1:0] ps, input logic [2:0] st,
                                       input logic [1:0] tc);
        return {ai, op, zx, mrd, mwr, irw, pcw, rw, rd, m2r, ps, st, tc};
    endfunction

    // 0 illegal, 1 R, 2 addi, 3 andi, 4 ori, 5 lw, 6 sw, 7 beq, 8 j
    function automatic int kind_of(input logic [31:0] ins);
        case (ins[31:26])
            6'h00: return (ins[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) ? 1 : 0;
            6'h08: return 2;
            6'h0C: return 3;
            6'h0D: return 4;
            6'h23: return 5;
            6'h2B: return 6;
            6'h04: return 7;
            6'h02: return 8;
            default: return 0;
        endcase
    endfunction

    // {ALUIMM, aluop, imm_zext} during the execute step of each instruction kind
    function automatic logic [4:0] ex_ctl(input int k, input logic [5:0] fn);
        case (k)
            1: case (fn)
                   6'h22:   return {1'b0, 3'd1, 1'b0};
                   6'h24:   return {1'b0, 3'd2, 1'b0};
                   6'h25:   return {1'b0, 3'd3, 1'b0};
                   6'h2A:   return {1'b0, 3'd4, 1'b0};
                   default: return {1'b0, 3'd0, 1'b0};
               endcase
            2, 5, 6: return {1'b1, 3'd0, 1'b0};
            3:       return {1'b1, 3'd2, 1'b1};
            4:       return {1'b1, 3'd3, 1'b1};
            7:       return {1'b0, 3'd1, 1'b0};
            default: return 5'd0;
        endcase
    endfunction

    task automatic push(input logic [18:0] e, input bit mr, input logic [31:0] ins, input bit z);
        q_exp.push_back(e);
        q_mr.push_back(mr);
        q_ins.push_back(ins);
        q_z.push_back(z);
    endtask

    // Expected cycle-by-cycle trace of one legal instruction; instr is junk outside DECODE
    task automatic model_instr(input logic [31:0] ins, input bit z, input int fd, input int md);
        int k;
        logic [4:0] ec;
        k  = kind_of(ins);
        ec = ex_ctl(k, ins[5:0]);
        for (int i = 0; i < fd; i++)
            push(pk(0, 3'd0, 0, 1, 0, 0, 0, 0, 0, 0, 2'd0, 3'd0, 2'd0), 1'b0, $urandom, 1'($urandom));
        push(pk(0, 3'd0, 0, 1, 0, 1, 1, 0, 0, 0, 2'd0, 3'd0, 2'd0), 1'b1, $urandom, 1'($urandom));
        if (k == 8) begin
            push(pk(0, 3'd0, 0, 0, 0, 0, 1, 0, 0, 0, 2'd2, 3'd1, 2'd0), 1'($urandom), ins, 1'($urandom));
            m_ret++;
            return;
        end
        push(pk(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 3'd1, 2'd0), 1'($urandom), ins, 1'($urandom));
        push(pk(ec[4], ec[3:1], ec[0], 0, 0, 0, (k == 7) && z, 0, 0, 0, (k == 7) ? 2'd1 : 2'd0, 3'd2, 2'd0),
             1'($urandom), $urandom, z);
        if (k == 7) begin
            m_ret++;
            return;
        end
        if (k == 5 || k == 6) begin
            for (int i = 0; i <= md; i++)
                push(pk(1, 3'd0, 0, k == 5, k == 6, 0, 0, 0, 0, 0, 2'd0, 3'd3, 2'd0), i == md, $urandom, 1'($urandom));
            if (k == 6) begin
                m_ret++;
                return;
            end
        end
        push(pk(ec[4], ec[3:1], ec[0], 0, 0, 0, 0, 1, k == 1, k == 5, 2'd0, 3'd4, 2'd0),
             1'($urandom), $urandom, 1'($urandom));
        m_ret++;
    endtask

    task automatic cyc(input bit mra, input bit mrb, input logic [31:0] ins, input bit z);
        @(negedge clk);
        a_mr  = mra;
        b_mr  = mrb;
        instr = ins;
        zero  = z;
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        a_mr  = 1'b0;
        b_mr  = 1'b0;
        instr = 32'd0;
        zero  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        checks++;
        if (a_obs !== 19'd0 || a_instret !== 16'd0) begin
            errors++;
            $display("FAIL reset_a obs=%h instret=%h required 0/0", a_obs, a_instret);
        end
        checks++;
        if (b_obs !== 19'd0 || b_instret !== 16'd0) begin
            errors++;
            $display("FAIL reset_b obs=%h instret=%h required 0/0", b_obs, b_instret);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        checks++;
        if (a_mrd !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle memread=%b required 0", a_mrd);
        end
        cyc(0, 0, 32'd0, 0);
        checks++;
        if (a_mrd !== 1'b1 || a_state !== 3'd0) begin
            errors++;
            $display("FAIL first_fetch memread=%b state=%0d required 1/0", a_mrd, a_state);
        end
    endtask

    task automatic test_addi();
        logic [2:0] st_e[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
        bit         ai_e[5] = '{0, 0, 1, 1, 0};
        bit         rw_e[5] = '{0, 0, 0, 1, 0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(i == 0, 0, (i == 1) ? 32'h20010005 : $urandom, 1'($urandom));
            checks++;
            if (a_state !== st_e[i] || a_aluimm !== ai_e[i] || a_rw !== rw_e[i]) begin
                errors++;
                $display("FAIL addi_c%0d state=%0d ALUIMM=%b regwrite=%b required %0d/%b/%b",
                         i, a_state, a_aluimm, a_rw, st_e[i], ai_e[i], rw_e[i]);
            end
        end
        checks++;
        if (a_instret !== 16'd1) begin
            errors++;
            $display("FAIL addi_instret got=%0d required 1", a_instret);
        end
    endtask

    task automatic test_add_sw();
        bit mr_e[13] = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0};
        int mw_cnt = 0;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            cyc(mr_e[i], 0, (i == 1) ? 32'h00221820 : (i == 5) ? 32'hAC010004 : $urandom, 0);
            if (a_mwr === 1'b1) mw_cnt++;
            if (i == 2 || i == 6) begin
                checks++;
                if (a_aluimm !== (i == 6) || a_aluop !== 3'd0 || a_state !== 3'd2) begin
                    errors++;
                    $display("FAIL add_sw_exec_c%0d ALUIMM=%b aluop=%0d state=%0d required %b/0/2",
                             i, a_aluimm, a_aluop, a_state, i == 6);
                end
            end
        end
        checks++;
        if (mw_cnt != 4) begin
            errors++;
            $display("FAIL sw_memwrite_cycles got=%0d required 4", mw_cnt);
        end
        checks++;
        if (a_instret !== 16'd2 || a_state !== 3'd0) begin
            errors++;
            $display("FAIL add_sw_end instret=%0d state=%0d required 2/0", a_instret, a_state);
        end
    endtask

    task automatic test_beq();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cyc(i == 0 || i == 3, 0, (i == 1 || i == 4) ? 32'h10220003 : $urandom, (i == 2));
            if (i == 2 || i == 5) begin
                checks++;
                if (a_state !== 3'd2 || a_aluimm !== 1'b0 || a_aluop !== 3'd1 ||
                    a_pcw !== (i == 2) || a_pcsrc !== 2'd1) begin
                    errors++;
                    $display("FAIL beq_exec_c%0d state=%0d ALUIMM=%b aluop=%0d pcwrite=%b pcsrc=%0d required 2/0/1/%b/1",
                             i, a_state, a_aluimm, a_aluop, a_pcw, a_pcsrc, i == 2);
                end
            end
        end
        checks++;
        if (a_instret !== 16'd2 || a_state !== 3'd0) begin
            errors++;
            $display("FAIL beq_retire instret=%0d state=%0d required 2/0", a_instret, a_state);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] bad;
        for (int k = 0; k < 2; k++) begin
            bad = (k == 0) ? 32'hFC000000 : 32'h00221801;
            do_reset();
            cyc(1, 0, $urandom, 0);
            cyc(0, 0, bad, 0);
            for (int i = 0; i < 22; i++) begin
                cyc(1'($urandom), 0, $urandom, 1'($urandom));
                checks++;
                if (a_state !== 3'd5 || a_tc !== 2'd1 || a_rw !== 1'b0 || a_mwr !== 1'b0 || a_mrd !== 1'b0) begin
                    errors++;
                    $display("FAIL illegal%0d_c%0d state=%0d cause=%0d regwrite=%b memwrite=%b required 5/1/0/0",
                             k, i, a_state, a_tc, a_rw, a_mwr);
                end
            end
            checks++;
            if (a_instret !== 16'd0) begin
                errors++;
                $display("FAIL illegal%0d_instret got=%0d required 0", k, a_instret);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, $urandom, 0);
            checks++;
            if (b_state !== 3'd0 || b_mrd !== 1'b1) begin
                errors++;
                $display("FAIL timeout_wait_c%0d state=%0d memread=%b required 0/1", i, b_state, b_mrd);
            end
        end
        cyc(0, 0, $urandom, 0);
        checks++;
        if (b_state !== 3'd5 || b_tc !== 2'd2 || b_mrd !== 1'b0) begin
            errors++;
            $display("FAIL timeout_trap state=%0d cause=%0d memread=%b required 5/2/0", b_state, b_tc, b_mrd);
        end
        do_reset();
        for (int i = 0; i < 4; i++) cyc(0, i == 3, $urandom, 0);
        checks++;
        if (b_irw !== 1'b1 || b_state !== 3'd0) begin
            errors++;
            $display("FAIL timeout_edge_ready irwrite=%b state=%0d required 1/0", b_irw, b_state);
        end
        cyc(0, 0, 32'h00221820, 0);
        checks++;
        if (b_state !== 3'd1 || b_tc !== 2'd0) begin
            errors++;
            $display("FAIL timeout_edge_decode state=%0d cause=%0d required 1/0", b_state, b_tc);
        end
    endtask

    task automatic test_abort_wrap();
        do_reset();
        cyc(1, 0, $urandom, 0);
        cyc(0, 0, 32'h8C010004, 0);
        cyc(0, 0, $urandom, 0);
        cyc(0, 0, $urandom, 0);
        checks++;
        if (a_state !== 3'd3 || a_mrd !== 1'b1) begin
            errors++;
            $display("FAIL lw_mem state=%0d memread=%b required 3/1", a_state, a_mrd);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (a_mrd !== 1'b0 || a_state !== 3'd0 || a_obs !== 19'd0) begin
            errors++;
            $display("FAIL reset_abort memread=%b state=%0d obs=%h required 0/0/0", a_mrd, a_state, a_obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 force dut_a.r_instret = 16'hFFFF;
        #1 release dut_a.r_instret;
        cyc(1, 0, $urandom, 0);
        checks++;
        if (a_instret !== 16'hFFFF) begin
            errors++;
            $display("FAIL preload instret=%h required ffff", a_instret);
        end
        cyc(0, 0, 32'h08000010, 0);
        cyc(0, 0, $urandom, 0);
        checks++;
        if (a_instret !== 16'h0000 || a_state !== 3'd0) begin
            errors++;
            $display("FAIL instret_wrap instret=%h state=%0d required 0000/0", a_instret, a_state);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins;
        logic [18:0] e;
        int k;
        do_reset();
        m_ret = 0;
        for (int n = 0; n < 40; n++) begin
            k   = $urandom_range(1, 8);
            ins = $urandom;
            if (k == 1) begin
                ins[31:26] = 6'h00;
                ins[5:0]   = functs[$urandom_range(0, 4)];
            end else begin
                ins[31:26] = ops[k];
            end
            model_instr(ins, 1'($urandom), $urandom_range(0, 14), $urandom_range(0, 14));
            while (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                cyc(q_mr.pop_front(), 1'b1, q_ins.pop_front(), q_z.pop_front());
                checks++;
                if (a_obs !== e) begin
                    errors++;
                    $display("FAIL b2b_instr%0d(%h) obs=%h required %h", n, ins, a_obs, e);
                end
            end
        end
        cyc(0, 1, $urandom, 0);
        checks++;
        if (a_instret !== 16'(m_ret)) begin
            errors++;
            $display("FAIL b2b_instret got=%0d required %0d", a_instret, m_ret);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_mr  = 1'b0;
        b_mr  = 1'b0;
        instr = 32'd0;
        zero  = 1'b0;
        test_reset();
        test_addi();
        test_add_sw();
        test_beq();
        test_illegal();
        test_timeout();
        test_abort_wrap();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/multi_cycle_controller.md
MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 Parameter TIMEOUT, default 15: max cycles to wait for mem_ready before a bus-error trap; range 1..255.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 instr  input  32  current instruction; [31:26] opcode, [5:0] funct; stable from DECODE onward.
REQ-005 zero  input  1  ALU zero flag; valid in EXEC.
REQ-006 mem_ready  input  1  memory handshake; completes the pending access in the cycle it is high.
REQ-007 ALUIMM  output  1  operand-B select to the reg/imm selector: 0 register, 1 immediate.
REQ-008 aluop  output  3  ALU operation: 0 add, 1 sub, 2 and, 3 or, 4 slt.
REQ-009 imm_zext  output  1  immediate extension: 1 zero-extend (andi/ori), 0 sign-extend.
REQ-010 Strobe outputs, each 1 bit: memread, memwrite, irwrite, pcwrite, regwrite, regdst (1 = rd), memtoreg (1 = memory data).
REQ-011 pcsrc  output  2  PC source: 0 PC+4, 1 branch target, 2 jump target.
REQ-012 state  output  3  current state encoding, for debug.
REQ-013 trap_cause  output  2  trap cause: 0 none, 1 illegal instruction, 2 memory timeout.
REQ-014 instret  output  16  count of retired instructions.

Function
REQ-015 The state encoding SHALL be: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6 and 7 SHALL go to TRAP with trap_cause=1.
REQ-016 Outputs SHALL be a combinational decode of the state and the latched opcode/funct. Any strobe not listed for a state SHALL be 0.
REQ-017 FETCH: memread=1. If mem_ready=1, assert irwrite=1, pcwrite=1 and pcsrc=0, then go to DECODE. Otherwise stay in FETCH.
REQ-018 DECODE: latch opcode and funct.
  - Legal set: R-type (opcode 0) with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A; addi 0x08, andi 0x0C, ori 0x0D, lw 0x23, sw 0x2B, beq 0x04, j 0x02.
  - Illegal: go to TRAP with trap_cause=1.
  - j: pcwrite=1, pcsrc=2, then FETCH; the instruction retires.
  - All other legal instructions: go to EXEC.
REQ-019 EXEC, per instruction class:
  - R-type: ALUIMM=0, aluop from funct, then WB.
  - addi/andi/ori: ALUIMM=1, aluop add/and/or, imm_zext=1 for andi/ori, then WB.
  - lw/sw: ALUIMM=1, aluop=0, imm_zext=0, then MEM.
  - beq: ALUIMM=0, aluop=1, pcsrc=1, pcwrite=zero, then FETCH; the instruction retires.
REQ-020 MEM: lw asserts memread, sw asserts memwrite; both hold until mem_ready=1. On mem_ready, sw goes to FETCH and retires; lw goes to WB.
REQ-021 WB: regwrite=1.
  - regdst=1 for R-type, else 0.
  - memtoreg=1 for lw, else 0.
  - ALUIMM and aluop keep their EXEC values.
  - Then go to FETCH; the instruction retires.
REQ-022 instr SHALL have no effect outside DECODE. ALUIMM SHALL never be X; it is 0 in FETCH, DECODE, TRAP and in undefined states.
REQ-023 A wait counter SHALL reset to 0 on entry to FETCH or MEM and increment each cycle mem_ready=0. When it reaches TIMEOUT with mem_ready still 0, the next state SHALL be TRAP with trap_cause=2. mem_ready=1 on that same cycle SHALL win: the access completes normally.
REQ-024 TRAP: all strobes 0. The block stays in TRAP until reset. trap_cause holds its value and is 0 in every other state.
REQ-025 instret SHALL increment by 1 on each retirement and wrap 0xFFFF to 0x0000. Trapped instructions SHALL not retire.

Reset
REQ-026 While rst_n=0:
  - State is forced to FETCH.
  - All strobes are forced to 0: memread, memwrite, irwrite, pcwrite, regwrite.
  - ALUIMM=0, aluop=0, pcsrc=0, trap_cause=0, instret=0, wait counter=0.
REQ-027 Reset asserted mid-access (FETCH/MEM) SHALL abort the access immediately, with no strobe glitch after the falling edge. The first FETCH SHALL begin on the first rising clk edge after rst_n rises.

Verification
REQ-028 addi (0x20010005), mem_ready=1 in FETCH: states 0,1,2,4,0; ALUIMM=1 in EXEC and WB; regwrite=1 only in WB; instret 0->1.
REQ-029 add (funct 0x20) then sw (0xAC010004) with mem_ready delayed 3 cycles in MEM: ALUIMM 0 then 1; memwrite high exactly 4 cycles; instret=2.
REQ-030 beq with zero=1, then beq with zero=0: pcwrite=1 with pcsrc=1 in EXEC only for the first; both retire; ALUIMM=0 in EXEC for both.
REQ-031 Opcode 0x3F, then R-type funct 0x01: TRAP with trap_cause=1; no regwrite or memwrite; state stays 5 for 20+ cycles; instret unchanged.
REQ-032 TIMEOUT=4, mem_ready held 0 in FETCH: TRAP after 4 wait cycles with trap_cause=2. Repeat with mem_ready=1 on the 4th wait cycle: goes to DECODE, no trap.
REQ-033 Reset pulsed in MEM of lw, then preload instret=0xFFFF and retire one instruction:
  - The reset aborts the lw: memread drops immediately and state=0.
  - The retirement wraps instret to 0x0000.
